hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32IM_Zbb core; the stall/flush counterpart of the forwarding unit.
- The forwarding unit resolves hazards by bypass; this block resolves the hazards that bypass cannot: load-use, branch operands not yet forwardable into ID, multi-cycle M-extension operations in EX, and control flushes on taken branches.
- Owns a start/done handshake with the multi-cycle mul/div unit, a watchdog on that handshake, and a stall-cycle performance counter.

Parameters:
- CNT_WIDTH, 32, width of the stall-cycle counter.
- BUSY_TIMEOUT, 64, maximum cycles in BUSY waiting for muldiv_done_i before abort.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- rs1_address_id_i  in  5  ID source register 1
- rs2_address_id_i  in  5  ID source register 2
- rs1_used_id_i  in  1  ID instruction reads rs1
- rs2_used_id_i  in  1  ID instruction reads rs2
- branch_id_i  in  1  ID instruction is a conditional branch
- branch_taken_id_i  in  1  branch or jump resolved taken in ID
- rd_we_ex_i  in  1  EX writes rd
- rd_address_ex_i  in  5  EX destination
- mem_to_reg_ex_i  in  1  EX instruction is a load
- muldiv_ex_i  in  1  EX instruction is a multi-cycle mul/div
- rd_we_mem_i  in  1  MEM writes rd
- rd_address_mem_i  in  5  MEM destination
- mem_to_reg_mem_i  in  1  MEM instruction is a load
- muldiv_done_i  in  1  mul/div result valid (single-cycle pulse)
- muldiv_start_o  out  1  one-cycle start pulse to the mul/div unit
- pc_en_o  out  1  PC register enable
- if_id_en_o  out  1  IF/ID register enable
- if_id_flush_o  out  1  insert bubble into IF/ID
- id_ex_en_o  out  1  ID/EX register enable
- id_ex_flush_o  out  1  insert bubble into ID/EX
- ex_mem_flush_o  out  1  insert bubble into EX/MEM
- muldiv_timeout_o  out  1  sticky watchdog error flag
- stall_cnt_o  out  CNT_WIDTH  total stalled cycles

Behaviour:
- Register x0 never causes a hazard: every match term requires the address to be non-zero.
- FSM states: IDLE and BUSY. Reset or abort returns to IDLE.
- IDLE with muldiv_ex_i=1: muldiv_start_o=1 for that cycle, state goes to BUSY, and the cycle is a muldiv stall.
- BUSY: muldiv_start_o=0, muldiv stall active.
  - muldiv_done_i=1: the stall releases in the same cycle, so EX/MEM captures the result; next state IDLE.
  - A back-to-back mul/div then reaching EX starts a new operation.
- Muldiv stall: pc_en_o, if_id_en_o and id_ex_en_o are 0; ex_mem_flush_o is 1.
- Watchdog: a counter clears on entry to BUSY.
  - If BUSY_TIMEOUT cycles elapse without done, state goes to IDLE and muldiv_timeout_o sets. It stays set until reset.
  - The EX instruction then advances with whatever result is present.
- Load-use, evaluated only when no muldiv stall: mem_to_reg_ex_i and rd_we_ex_i are 1, and rd_address_ex_i matches a used ID source.
  - Response: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1.
- Branch hazard, evaluated only when no muldiv stall and branch_id_i=1. Either condition gives the same response as load-use:
  - (a) rd_we_ex_i and rd_address_ex_i matches a used ID source (result not yet in MEM);
  - (b) rd_we_mem_i, mem_to_reg_mem_i, and rd_address_mem_i matches a used ID source (load data is not forwardable from MEM).
- Priority: muldiv stall > load-use = branch hazard > taken-branch flush.
- Taken-branch flush: with no stall, branch_taken_id_i=1 gives if_id_flush_o=1 with PC enabled. Whenever any stall is active, branch_taken_id_i is ignored.
- Idle default: all enables 1, all flushes 0, muldiv_start_o=0.
- Outputs are combinational from state and inputs. State, watchdog, counter and sticky flag are registered.
- stall_cnt_o increments on every cycle with pc_en_o=0 outside reset, and wraps modulo 2^CNT_WIDTH.
- While reset=1:
  - pc_en_o, if_id_en_o, id_ex_en_o and muldiv_start_o are 0;
  - all flushes are 1;
  - stall_cnt_o and muldiv_timeout_o clear to 0; state is IDLE.
  - Reset asserted mid-BUSY abandons the operation with no start pulse; a late done is ignored in IDLE.

Decomposition:
- Shared package rv_pkg:
  - FSM state encoding (IDLE, BUSY);
  - REG_ZERO constant (5'd0);
  - default BUSY_TIMEOUT.
- One sub-module, muldiv_tracker: FSM, watchdog counter, start pulse and timeout flag.
- The top level holds the combinational hazard detection, priority merge and stall counter.

Test Plan:
- EX load x5, ID add using x5 (rs1_used=1) -> one cycle with pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, stall_cnt_o=1; next cycle all clear.
- EX load x0, ID reads x0 -> no stall; stall_cnt_o stays 0.
- muldiv_ex_i=1, done asserted 4 cycles after start -> muldiv_start_o pulses exactly once, ex_mem_flush_o=1 for 4 cycles, release on the done cycle, stall_cnt_o=4.
- ID beq x7 with EX writing x7 -> 1-cycle stall; ID beq x7 with MEM load x7 -> 1-cycle stall; MEM ALU write to x7 -> no stall.
- Taken branch with no hazard -> if_id_flush_o=1 for 1 cycle, pc_en_o=1; taken branch during muldiv BUSY -> no flush.
- Done withheld for 64 cycles -> return to IDLE, muldiv_timeout_o=1 and sticky; reset asserted in BUSY -> outputs at reset values, late done ignored.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32IM_Zbb pipeline control blocks.
package rv_pkg;

    localparam int unsigned REG_ADDR_W       = 5;
    localparam logic [4:0]  REG_ZERO         = 5'd0;
    localparam int unsigned DEF_BUSY_TIMEOUT = 64;

    // Multi-cycle mul/div handshake states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // True when a used source register is produced by a real (non-x0) destination
    function automatic logic src_match(
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  used
    );
        return used && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_unit_muldiv_tracker.sv
// Tracks the start/done handshake with the multi-cycle mul/div unit,
// including a watchdog that aborts a stuck operation and latches an error.
module muldiv_tracker
    import rv_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic muldiv_ex_i,
    input  logic muldiv_done_i,
    output logic muldiv_start_o,
    output logic muldiv_stall_o,
    output logic muldiv_timeout_o
);

    localparam int unsigned WD_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(BUSY_TIMEOUT - 1);

    md_state_e       state_r;
    md_state_e       state_s;
    logic [WD_W-1:0] wd_r;
    logic            abort_s;
    logic            timeout_r;

    // Next-state and handshake outputs; reset suppresses any start pulse
    always_comb begin
        state_s        = state_r;
        muldiv_start_o = 1'b0;
        muldiv_stall_o = 1'b0;
        abort_s        = 1'b0;
        if (reset) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (muldiv_ex_i) begin
                        muldiv_start_o = 1'b1;
                        muldiv_stall_o = 1'b1;
                        state_s        = ST_BUSY;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (muldiv_done_i) begin
                        // Release in the done cycle so EX/MEM captures the result
                        state_s = ST_IDLE;
                    end else if (wd_r == WD_LAST) begin
                        // Give up: let the EX instruction advance with what it has
                        abort_s = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        muldiv_stall_o = 1'b1;
                        state_s        = ST_BUSY;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register, watchdog counter (cleared on entry to BUSY) and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            wd_r      <= '0;
            timeout_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_BUSY) && (state_s == ST_BUSY)) begin
                wd_r <= wd_r + WD_W'(1);
            end else begin
                wd_r <= '0;
            end
            timeout_r <= timeout_r | abort_s;
        end
    end

    assign muldiv_timeout_o = timeout_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller: load-use, branch-operand and mul/div
// stalls, taken-branch flushes, and a stall-cycle performance counter.
module hazard_unit
    import rv_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            rs1_address_id_i,
    input  logic [4:0]            rs2_address_id_i,
    input  logic                  rs1_used_id_i,
    input  logic                  rs2_used_id_i,
    input  logic                  branch_id_i,
    input  logic                  branch_taken_id_i,
    input  logic                  rd_we_ex_i,
    input  logic [4:0]            rd_address_ex_i,
    input  logic                  mem_to_reg_ex_i,
    input  logic                  muldiv_ex_i,
    input  logic                  rd_we_mem_i,
    input  logic [4:0]            rd_address_mem_i,
    input  logic                  mem_to_reg_mem_i,
    input  logic                  muldiv_done_i,
    output logic                  muldiv_start_o,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_en_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_flush_o,
    output logic                  muldiv_timeout_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    logic                 muldiv_stall_s;
    logic                 ex_match_s;
    logic                 mem_match_s;
    logic                 load_use_s;
    logic                 branch_haz_s;
    logic [CNT_WIDTH-1:0] stall_cnt_r;

    muldiv_tracker #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) u_tracker (
        .clk              (clk),
        .reset            (reset),
        .muldiv_ex_i      (muldiv_ex_i),
        .muldiv_done_i    (muldiv_done_i),
        .muldiv_start_o   (muldiv_start_o),
        .muldiv_stall_o   (muldiv_stall_s),
        .muldiv_timeout_o (muldiv_timeout_o)
    );

    // Dependency detection against EX and MEM destinations (x0 never matches)
    always_comb begin
        ex_match_s   = src_match(rd_address_ex_i, rs1_address_id_i, rs1_used_id_i) ||
                       src_match(rd_address_ex_i, rs2_address_id_i, rs2_used_id_i);
        mem_match_s  = src_match(rd_address_mem_i, rs1_address_id_i, rs1_used_id_i) ||
                       src_match(rd_address_mem_i, rs2_address_id_i, rs2_used_id_i);
        load_use_s   = mem_to_reg_ex_i && rd_we_ex_i && ex_match_s;
        // Branches compare in ID, so an EX result or a MEM load is still too late
        branch_haz_s = branch_id_i &&
                       ((rd_we_ex_i && ex_match_s) ||
                        (rd_we_mem_i && mem_to_reg_mem_i && mem_match_s));
    end

    // Priority merge: reset > muldiv stall > load-use/branch stall > taken flush
    always_comb begin
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (reset) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (muldiv_stall_s) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_flush_o = 1'b1;
        end else if (load_use_s || branch_haz_s) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end else if (branch_taken_id_i) begin
            if_id_flush_o = 1'b1;
        end else begin
            if_id_flush_o = 1'b0;
        end
    end

    // Stall-cycle counter: every non-reset cycle with the PC frozen, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (!pc_en_o) begin
            stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_address_id, rs2_address_id;
    logic        rs1_used_id, rs2_used_id, branch_id, branch_taken_id;
    logic        rd_we_ex, mem_to_reg_ex, muldiv_ex;
    logic [4:0]  rd_address_ex, rd_address_mem;
    logic        rd_we_mem, mem_to_reg_mem, muldiv_done;
    logic        muldiv_start, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush;
    logic        muldiv_timeout;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_WIDTH(32), .BUSY_TIMEOUT(64)) dut (
        .clk               (clk),
        .reset             (reset),
        .rs1_address_id_i  (rs1_address_id),
        .rs2_address_id_i  (rs2_address_id),
        .rs1_used_id_i     (rs1_used_id),
        .rs2_used_id_i     (rs2_used_id),
        .branch_id_i       (branch_id),
        .branch_taken_id_i (branch_taken_id),
        .rd_we_ex_i        (rd_we_ex),
        .rd_address_ex_i   (rd_address_ex),
        .mem_to_reg_ex_i   (mem_to_reg_ex),
        .muldiv_ex_i       (muldiv_ex),
        .rd_we_mem_i       (rd_we_mem),
        .rd_address_mem_i  (rd_address_mem),
        .mem_to_reg_mem_i  (mem_to_reg_mem),
        .muldiv_done_i     (muldiv_done),
        .muldiv_start_o    (muldiv_start),
        .pc_en_o           (pc_en),
        .if_id_en_o        (if_id_en),
        .if_id_flush_o     (if_id_flush),
        .id_ex_en_o        (id_ex_en),
        .id_ex_flush_o     (id_ex_flush),
        .ex_mem_flush_o    (ex_mem_flush),
        .muldiv_timeout_o  (muldiv_timeout),
        .stall_cnt_o       (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and checks happen just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_address_id = 5'd0; rs2_address_id = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        branch_id = 1'b0; branch_taken_id = 1'b0;
        rd_we_ex = 1'b0; rd_address_ex = 5'd0; mem_to_reg_ex = 1'b0; muldiv_ex = 1'b0;
        rd_we_mem = 1'b0; rd_address_mem = 5'd0; mem_to_reg_mem = 1'b0; muldiv_done = 1'b0;
    endtask

    // Packs {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, start}
    function automatic logic [31:0] ctl();
        return {25'd0, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, muldiv_start};
    endfunction

    localparam logic [31:0] CTL_IDLE     = 32'b1110000;
    localparam logic [31:0] CTL_RESET    = 32'b0001110;
    localparam logic [31:0] CTL_HAZ      = 32'b0010100;
    localparam logic [31:0] CTL_MD       = 32'b0000010;
    localparam logic [31:0] CTL_MD_START = 32'b0000011;
    localparam logic [31:0] CTL_TAKEN    = 32'b1111000;

    initial begin
        idle_inputs();
        // Reset state, with a mul/div request that must not start
        reset = 1'b1;
        muldiv_ex = 1'b1;
        #1;
        check_eq("reset_ctl", ctl(), CTL_RESET);
        tick(); tick();
        check_eq("reset_ctl2", ctl(), CTL_RESET);
        check_eq("reset_cnt", stall_cnt, 32'd0);
        check_eq("reset_tmo", {31'd0, muldiv_timeout}, 32'd0);
        reset = 1'b0;
        idle_inputs();
        #1;
        check_eq("idle_ctl", ctl(), CTL_IDLE);
        tick();
        check_eq("idle_cnt", stall_cnt, 32'd0);

        // Load-use on x5 (taken flag must be masked by the stall)
        mem_to_reg_ex = 1'b1; rd_we_ex = 1'b1; rd_address_ex = 5'd5;
        rs1_address_id = 5'd5; rs1_used_id = 1'b1; branch_taken_id = 1'b1;
        #1;
        check_eq("lu_ctl", ctl(), CTL_HAZ);
        tick();
        check_eq("lu_cnt", stall_cnt, 32'd1);
        idle_inputs();
        #1;
        check_eq("lu_clear_ctl", ctl(), CTL_IDLE);
        tick();
        check_eq("lu_clear_cnt", stall_cnt, 32'd1);

        // Load to x0 read by ID: no hazard
        mem_to_reg_ex = 1'b1; rd_we_ex = 1'b1; rd_address_ex = 5'd0;
        rs1_used_id = 1'b1; rs2_used_id = 1'b1;
        #1;
        check_eq("x0_ctl", ctl(), CTL_IDLE);
        tick();
        check_eq("x0_cnt", stall_cnt, 32'd1);

        // Load-use via rs2 only when rs2 is actually used
        idle_inputs();
        mem_to_reg_ex = 1'b1; rd_we_ex = 1'b1; rd_address_ex = 5'd9; rs2_address_id = 5'd9;
        #1;
        check_eq("rs2_unused_ctl", ctl(), CTL_IDLE);
        rs2_used_id = 1'b1;
        #1;
        check_eq("rs2_used_ctl", ctl(), CTL_HAZ);
        tick();
        check_eq("rs2_cnt", stall_cnt, 32'd2);

        // Branch on x7 with EX ALU writing x7
        idle_inputs();
        branch_id = 1'b1; rs1_address_id = 5'd7; rs1_used_id = 1'b1;
        rd_we_ex = 1'b1; rd_address_ex = 5'd7;
        #1;
        check_eq("br_ex_ctl", ctl(), CTL_HAZ);
        tick();
        check_eq("br_ex_cnt", stall_cnt, 32'd3);
        // Branch on x7 with MEM load x7
        rd_we_ex = 1'b0;
        rd_we_mem = 1'b1; mem_to_reg_mem = 1'b1; rd_address_mem = 5'd7;
        #1;
        check_eq("br_memld_ctl", ctl(), CTL_HAZ);
        tick();
        check_eq("br_memld_cnt", stall_cnt, 32'd4);
        // MEM ALU write x7 is forwardable
        mem_to_reg_mem = 1'b0;
        #1;
        check_eq("br_memalu_ctl", ctl(), CTL_IDLE);
        // Same EX ALU write with a non-branch: forwardable
        idle_inputs();
        rs1_address_id = 5'd7; rs1_used_id = 1'b1; rd_we_ex = 1'b1; rd_address_ex = 5'd7;
        #1;
        check_eq("alu_ex_ctl", ctl(), CTL_IDLE);
        tick();
        check_eq("br_memalu_cnt", stall_cnt, 32'd4);

        // Taken branch without hazard
        idle_inputs();
        branch_id = 1'b1; branch_taken_id = 1'b1;
        #1;
        check_eq("taken_ctl", ctl(), CTL_TAKEN);
        tick();
        idle_inputs();
        #1;
        check_eq("taken_clear_ctl", ctl(), CTL_IDLE);
        check_eq("taken_cnt", stall_cnt, 32'd4);

        // Mul/div with done four cycles after start
        muldiv_ex = 1'b1;
        #1;
        check_eq("md_start_ctl", ctl(), CTL_MD_START);
        for (int i = 1; i <= 3; i++) begin
            tick();
            branch_taken_id = (i == 2) ? 1'b1 : 1'b0;
            #1;
            check_eq($sformatf("md_busy%0d_ctl", i), ctl(), CTL_MD);
        end
        tick();
        branch_taken_id = 1'b0;
        muldiv_done = 1'b1;
        #1;
        check_eq("md_done_ctl", ctl(), CTL_IDLE);
        tick();
        idle_inputs();
        #1;
        check_eq("md_cnt", stall_cnt, 32'd8);
        check_eq("md_after_ctl", ctl(), CTL_IDLE);

        // Watchdog: done withheld, BUSY gives up after 64 cycles
        muldiv_ex = 1'b1;
        #1;
        check_eq("wd_start_ctl", ctl(), CTL_MD_START);
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (ctl() !== CTL_MD) begin
                check_eq($sformatf("wd_busy%0d_ctl", i), ctl(), CTL_MD);
            end
        end
        check_eq("wd_busy63_ctl", ctl(), CTL_MD);
        check_eq("wd_tmo_early", {31'd0, muldiv_timeout}, 32'd0);
        tick();
        check_eq("wd_abort_ctl", ctl(), CTL_IDLE);
        tick();
        idle_inputs();
        #1;
        check_eq("wd_tmo_set", {31'd0, muldiv_timeout}, 32'd1);
        check_eq("wd_cnt", stall_cnt, 32'd72);
        tick(); tick();
        check_eq("wd_tmo_sticky", {31'd0, muldiv_timeout}, 32'd1);

        // Reset in the middle of BUSY, then a late done
        muldiv_ex = 1'b1;
        tick();
        #1;
        check_eq("rb_busy_ctl", ctl(), CTL_MD);
        reset = 1'b1;
        #1;
        check_eq("rb_reset_ctl", ctl(), CTL_RESET);
        tick();
        check_eq("rb_cnt", stall_cnt, 32'd0);
        check_eq("rb_tmo", {31'd0, muldiv_timeout}, 32'd0);
        reset = 1'b0;
        muldiv_ex = 1'b0;
        muldiv_done = 1'b1;
        #1;
        check_eq("rb_late_done_ctl", ctl(), CTL_IDLE);
        tick();
        muldiv_done = 1'b0;
        #1;
        check_eq("rb_after_ctl", ctl(), CTL_IDLE);
        check_eq("rb_after_cnt", stall_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
